// File: rtl/adc_clk_pkg.sv
// Shared types and defaults for the multi-channel ADC clock lock monitor.
package adc_clk_pkg;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOST   = 2'd2
    } ch_state_e;

    localparam int DEF_LOCK_CYCLES    = 512;
    localparam int DEF_WDOG_CYCLES    = 16;
    localparam int DEF_HOLDOFF_CYCLES = 64;
    localparam int DEF_LOST_CNT_W     = 8;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_lock_ch.sv
// One monitored channel: heartbeat synchroniser, watchdog, lock FSM and loss counter.
module clk_lock_ch
    import adc_clk_pkg::*;
#(
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int WDOG_CYCLES    = DEF_WDOG_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int LOST_CNT_W     = DEF_LOST_CNT_W
) (
    input  logic                  clk_div,
    input  logic                  sys_rst,
    input  logic                  hb,
    input  logic                  reseek,
    input  logic                  lost_clr,
    output logic                  locked,
    output logic                  dn_rst,
    output logic                  lost_sticky,
    output logic [LOST_CNT_W-1:0] lost_cnt
);

    localparam int LW = cnt_w(LOCK_CYCLES - 1);
    localparam int WW = cnt_w(WDOG_CYCLES);
    localparam int HW = cnt_w(HOLDOFF_CYCLES - 1);

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    logic            s1, s2, s3, act, timeout, loss;
    logic [WW-1:0]   wdog_cnt;
    logic [LW-1:0]   lock_cnt, lock_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    ch_state_e       st, st_nxt;
    logic            locked_nxt, sticky_nxt;
    logic [LOST_CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk_div) begin
        if (sys_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= hb;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign act = s2 ^ s3;

    always_ff @(posedge clk_div) begin
        if (sys_rst || reseek || act)
            wdog_cnt <= '0;
        else if (wdog_cnt != WDOG_MAX)
            wdog_cnt <= wdog_cnt + WW'(1);
    end

    // Stays asserted while saturated so a dead channel pins lock_cnt at 0 in ACQ.
    assign timeout = !act && (wdog_cnt >= WDOG_LAST);

    always_comb begin
        st_nxt     = st;
        lock_nxt   = lock_cnt;
        hold_nxt   = hold_cnt;
        locked_nxt = locked;
        loss       = 1'b0;
        if (reseek) begin
            st_nxt     = ST_ACQ;
            lock_nxt   = '0;
            hold_nxt   = '0;
            locked_nxt = 1'b0;
        end else begin
            case (st)
                ST_ACQ: begin
                    if (timeout)
                        lock_nxt = '0;
                    else if (lock_cnt == LOCK_LAST) begin
                        st_nxt     = ST_LOCKED;
                        locked_nxt = 1'b1;
                    end else
                        lock_nxt = lock_cnt + LW'(1);
                end
                ST_LOCKED: begin
                    if (timeout) begin
                        st_nxt     = ST_LOST;
                        locked_nxt = 1'b0;
                        loss       = 1'b1;
                    end
                end
                ST_LOST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        st_nxt   = ST_ACQ;
                        hold_nxt = '0;
                        lock_nxt = '0;
                    end else
                        hold_nxt = hold_cnt + HW'(1);
                end
                default: begin
                    st_nxt     = ST_ACQ;
                    lock_nxt   = '0;
                    hold_nxt   = '0;
                    locked_nxt = 1'b0;
                end
            endcase
        end

        // A loss on the same edge as lost_clr wins and counts as the first loss.
        sticky_nxt = lost_sticky;
        cnt_nxt    = lost_cnt;
        if (loss) begin
            sticky_nxt = 1'b1;
            if (lost_clr)
                cnt_nxt = LOST_CNT_W'(1);
            else if (lost_cnt != '1)
                cnt_nxt = lost_cnt + LOST_CNT_W'(1);
        end else if (lost_clr) begin
            sticky_nxt = 1'b0;
            cnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk_div) begin
        if (sys_rst) begin
            st          <= ST_ACQ;
            lock_cnt    <= '0;
            hold_cnt    <= '0;
            locked      <= 1'b0;
            dn_rst      <= 1'b1;
            lost_sticky <= 1'b0;
            lost_cnt    <= '0;
        end else begin
            st          <= st_nxt;
            lock_cnt    <= lock_nxt;
            hold_cnt    <= hold_nxt;
            locked      <= locked_nxt;
            dn_rst      <= ~locked_nxt;
            lost_sticky <= sticky_nxt;
            lost_cnt    <= cnt_nxt;
        end
    end

endmodule

// File: rtl/adc_clk_lock_mon.sv
// N_CH-channel ADC clock lock monitor: per-channel lock engines plus registered all_locked.
module adc_clk_lock_mon
    import adc_clk_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int WDOG_CYCLES    = DEF_WDOG_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int LOST_CNT_W     = DEF_LOST_CNT_W
) (
    input  logic                       clk_div,
    input  logic                       sys_rst,
    input  logic [N_CH-1:0]            ch_hb,
    input  logic [N_CH-1:0]            ch_reseek,
    input  logic                       lost_clr,
    output logic [N_CH-1:0]            ch_locked,
    output logic [N_CH-1:0]            ch_rst,
    output logic                       all_locked,
    output logic [N_CH-1:0]            ch_lost_sticky,
    output logic [N_CH*LOST_CNT_W-1:0] ch_lost_cnt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_lock_ch #(
            .LOCK_CYCLES    (LOCK_CYCLES),
            .WDOG_CYCLES    (WDOG_CYCLES),
            .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
            .LOST_CNT_W     (LOST_CNT_W)
        ) u_ch (
            .clk_div     (clk_div),
            .sys_rst     (sys_rst),
            .hb          (ch_hb[i]),
            .reseek      (ch_reseek[i]),
            .lost_clr    (lost_clr),
            .locked      (ch_locked[i]),
            .dn_rst      (ch_rst[i]),
            .lost_sticky (ch_lost_sticky[i]),
            .lost_cnt    (ch_lost_cnt[i*LOST_CNT_W +: LOST_CNT_W])
        );
    end

    always_ff @(posedge clk_div) begin
        if (sys_rst)
            all_locked <= 1'b0;
        else
            all_locked <= &ch_locked;
    end

endmodule

// File: tb/tb_adc_clk_lock_mon.sv
// Bench for adc_clk_lock_mon: directed vector table, loss-counter sequences, random run vs model.
module tb_adc_clk_lock_mon;

    localparam int N    = 4;
    localparam int LOCK = 24;
    localparam int WDOG = 6;
    localparam int HOLD = 5;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int NV   = 20;

    logic            clk_div = 1'b0;
    logic            sys_rst;
    logic [N-1:0]    ch_hb, ch_reseek;
    logic            lost_clr;
    logic [N-1:0]    ch_locked, ch_rst, ch_lost_sticky;
    logic            all_locked;
    logic [N*CW-1:0] ch_lost_cnt;

    adc_clk_lock_mon #(
        .N_CH(N), .LOCK_CYCLES(LOCK), .WDOG_CYCLES(WDOG),
        .HOLDOFF_CYCLES(HOLD), .LOST_CNT_W(CW)
    ) dut (
        .clk_div(clk_div), .sys_rst(sys_rst), .ch_hb(ch_hb), .ch_reseek(ch_reseek),
        .lost_clr(lost_clr), .ch_locked(ch_locked), .ch_rst(ch_rst),
        .all_locked(all_locked), .ch_lost_sticky(ch_lost_sticky), .ch_lost_cnt(ch_lost_cnt)
    );

    always #5 clk_div = ~clk_div;

    int total = 0, bad = 0, cyc = 0;

    // heartbeat generator: per[c]=0 means the channel clock is dead
    int       per [N];
    int       ph  [N];
    logic [N-1:0] hb_v;

    // reference model, kept as plain counters of elapsed cycles
    localparam int M_ACQ = 0, M_LCK = 1, M_LOST = 2;
    int       m_mode [N];
    int       m_acq  [N];
    int       m_hold [N];
    int       m_idle [N];
    int       m_cnt  [N];
    logic     m_lock [N];
    logic     m_stk  [N];
    logic     m_all;
    logic [2:0] samp [N];   // hb as seen 1, 2 and 3 edges ago

    function automatic logic m_act(input int c);
        return samp[c][1] ^ samp[c][2];
    endfunction

    function automatic logic loss_next(input int c);
        return (m_mode[c] == M_LCK) && !m_act(c) && (m_idle[c] >= WDOG - 1);
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] rs, input logic clr,
                              input logic [N-1:0] hb);
        logic all_n, to, loss;
        if (r) begin
            for (int c = 0; c < N; c++) begin
                m_mode[c] = M_ACQ; m_acq[c] = 0; m_hold[c] = 0; m_idle[c] = 0;
                m_cnt[c] = 0; m_lock[c] = 1'b0; m_stk[c] = 1'b0; samp[c] = 3'b000;
            end
            m_all = 1'b0;
        end else begin
            all_n = 1'b1;
            for (int c = 0; c < N; c++) all_n = all_n & m_lock[c];
            for (int c = 0; c < N; c++) begin
                to   = !m_act(c) && (m_idle[c] >= WDOG - 1);
                loss = 1'b0;
                if (rs[c]) begin
                    m_mode[c] = M_ACQ; m_acq[c] = 0; m_hold[c] = 0; m_idle[c] = 0;
                    m_lock[c] = 1'b0;
                end else begin
                    if (m_act(c)) m_idle[c] = 0;
                    else if (m_idle[c] < WDOG) m_idle[c]++;
                    if (m_mode[c] == M_ACQ) begin
                        if (to) m_acq[c] = 0;
                        else if (m_acq[c] + 1 == LOCK) begin m_mode[c] = M_LCK; m_lock[c] = 1'b1; end
                        else m_acq[c]++;
                    end else if (m_mode[c] == M_LCK) begin
                        if (to) begin m_mode[c] = M_LOST; m_lock[c] = 1'b0; loss = 1'b1; end
                    end else begin
                        if (m_hold[c] + 1 == HOLD) begin m_mode[c] = M_ACQ; m_hold[c] = 0; m_acq[c] = 0; end
                        else m_hold[c]++;
                    end
                end
                if (loss) begin
                    m_stk[c] = 1'b1;
                    m_cnt[c] = clr ? 1 : ((m_cnt[c] < MAXC) ? m_cnt[c] + 1 : MAXC);
                end else if (clr) begin
                    m_stk[c] = 1'b0; m_cnt[c] = 0;
                end
                samp[c] = {samp[c][1:0], hb[c]};
            end
            m_all = all_n;
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] rs, input logic clr);
        logic [N-1:0]    el, es;
        logic [N*CW-1:0] ec;
        if (r) begin
            hb_v = '0;
            for (int c = 0; c < N; c++) ph[c] = 0;
        end else begin
            for (int c = 0; c < N; c++)
                if (per[c] != 0) begin
                    if (ph[c] == 0) hb_v[c] = ~hb_v[c];
                    ph[c] = (ph[c] + 1) % per[c];
                end
        end
        ch_hb = hb_v; sys_rst = r; ch_reseek = rs; lost_clr = clr;
        @(posedge clk_div);
        model_edge(r, rs, clr, hb_v);
        #1;
        cyc++;
        for (int c = 0; c < N; c++) begin
            el[c] = m_lock[c]; es[c] = m_stk[c]; ec[c*CW +: CW] = CW'(m_cnt[c]);
        end
        total++;
        if ({ch_locked, ch_rst, all_locked, ch_lost_sticky, ch_lost_cnt} !== {el, ~el, m_all, es, ec}) begin
            bad++;
            $display("FAIL model cyc=%0d got lock=%b rst=%b all=%b stk=%b cnt=%h want lock=%b rst=%b all=%b stk=%b cnt=%h",
                     cyc, ch_locked, ch_rst, all_locked, ch_lost_sticky, ch_lost_cnt, el, ~el, m_all, es, ec);
        end
    endtask

    task automatic set_per(input int c, input int p);
        if (per[c] != p) begin per[c] = p; ph[c] = 0; end
    endtask

    typedef struct {
        int          n;
        logic        rst;
        logic [3:0]  rs;
        logic        clr;
        int          p0, p1, p2, p3;
        logic [3:0]  el;
        logic        ea;
        logic [3:0]  es;
        logic [11:0] ec;
    } vec_t;

    vec_t tbl [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  choices [8];
        logic hit;
        logic [N-1:0] rsr;
        choices = '{0, 2, 3, 4, 5, 6, 7, 9};
        hb_v = '0;
        for (int c = 0; c < N; c++) begin per[c] = 2; ph[c] = 0; end
        ch_hb = '0; sys_rst = 1'b1; ch_reseek = '0; lost_clr = 1'b0;

        //          n  rst rs    clr  periods       lock  all   stk   cnt
        tbl[0]  = '{3,  1, 4'h0, 0, 2, 2, 2, 2, 4'h0, 1'b0, 4'h0, 12'h000};
        tbl[1]  = '{23, 0, 4'h0, 0, 2, 2, 2, 2, 4'h0, 1'b0, 4'h0, 12'h000};
        tbl[2]  = '{1,  0, 4'h0, 0, 2, 2, 2, 2, 4'hF, 1'b0, 4'h0, 12'h000};
        tbl[3]  = '{1,  0, 4'h0, 0, 2, 2, 2, 2, 4'hF, 1'b1, 4'h0, 12'h000};
        tbl[4]  = '{2,  1, 4'h0, 0, 2, 2, 2, 2, 4'h0, 1'b0, 4'h0, 12'h000};
        tbl[5]  = '{24, 0, 4'h0, 0, 2, 2, 4, 7, 4'h7, 1'b0, 4'h0, 12'h000};
        tbl[6]  = '{35, 0, 4'h0, 0, 2, 2, 4, 2, 4'hF, 1'b1, 4'h0, 12'h000};
        tbl[7]  = '{12, 0, 4'h0, 0, 2, 0, 4, 2, 4'hD, 1'b0, 4'h2, 12'h008};
        tbl[8]  = '{10, 0, 4'h0, 0, 2, 2, 4, 2, 4'hD, 1'b0, 4'h2, 12'h008};
        tbl[9]  = '{30, 0, 4'h0, 0, 2, 2, 4, 2, 4'hF, 1'b1, 4'h2, 12'h008};
        tbl[10] = '{1,  0, 4'h4, 0, 2, 2, 4, 2, 4'hB, 1'b1, 4'h2, 12'h008};
        tbl[11] = '{1,  0, 4'h0, 0, 2, 2, 4, 2, 4'hB, 1'b0, 4'h2, 12'h008};
        tbl[12] = '{22, 0, 4'h0, 0, 2, 2, 4, 2, 4'hB, 1'b0, 4'h2, 12'h008};
        tbl[13] = '{1,  0, 4'h0, 0, 2, 2, 4, 2, 4'hF, 1'b0, 4'h2, 12'h008};
        tbl[14] = '{1,  0, 4'h0, 0, 2, 2, 4, 2, 4'hF, 1'b1, 4'h2, 12'h008};
        tbl[15] = '{10, 0, 4'h0, 0, 0, 2, 4, 2, 4'hE, 1'b0, 4'h3, 12'h009};
        tbl[16] = '{1,  1, 4'h0, 0, 0, 2, 4, 2, 4'h0, 1'b0, 4'h0, 12'h000};
        tbl[17] = '{23, 0, 4'h0, 0, 2, 2, 2, 2, 4'h0, 1'b0, 4'h0, 12'h000};
        tbl[18] = '{1,  0, 4'h0, 0, 2, 2, 2, 2, 4'hF, 1'b0, 4'h0, 12'h000};
        tbl[19] = '{1,  0, 4'h0, 0, 2, 2, 2, 2, 4'hF, 1'b1, 4'h0, 12'h000};

        for (int i = 0; i < NV; i++) begin
            set_per(0, tbl[i].p0); set_per(1, tbl[i].p1);
            set_per(2, tbl[i].p2); set_per(3, tbl[i].p3);
            for (int k = 0; k < tbl[i].n; k++)
                tick(tbl[i].rst, (k == 0) ? tbl[i].rs : 4'h0, (k == 0) ? tbl[i].clr : 1'b0);
            total++;
            if ({ch_locked, all_locked, ch_lost_sticky, ch_lost_cnt} !==
                {tbl[i].el, tbl[i].ea, tbl[i].es, tbl[i].ec}) begin
                bad++;
                $display("FAIL vec%0d got lock=%b all=%b stk=%b cnt=%h want lock=%b all=%b stk=%b cnt=%h",
                         i, ch_locked, all_locked, ch_lost_sticky, ch_lost_cnt,
                         tbl[i].el, tbl[i].ea, tbl[i].es, tbl[i].ec);
            end
        end

        // repeated losses on channel 0: counter climbs then saturates
        for (int i = 0; i < MAXC + 2; i++) begin
            set_per(0, 0);
            for (int k = 0; k < 12; k++) tick(1'b0, '0, 1'b0);
            set_per(0, 2);
            for (int k = 0; k < 40; k++) tick(1'b0, '0, 1'b0);
            total++;
            if (ch_lost_cnt[CW-1:0] !== CW'((i + 1 < MAXC) ? i + 1 : MAXC) || ch_lost_sticky !== 4'b0001 ||
                ch_locked !== 4'hF) begin
                bad++;
                $display("FAIL sat%0d got cnt0=%0d stk=%b lock=%b want cnt0=%0d stk=0001 lock=1111",
                         i, ch_lost_cnt[CW-1:0], ch_lost_sticky, ch_locked, (i + 1 < MAXC) ? i + 1 : MAXC);
            end
        end

        // lost_clr on the very edge of a new loss
        set_per(0, 0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (loss_next(0)) begin
                hit = 1'b1;
                tick(1'b0, '0, 1'b1);
            end else
                tick(1'b0, '0, 1'b0);
        end
        total++;
        if (!hit || ch_lost_sticky !== 4'b0001 || ch_lost_cnt !== 12'h001) begin
            bad++;
            $display("FAIL clr_vs_loss hit=%0d got stk=%b cnt=%h want stk=0001 cnt=001",
                     hit, ch_lost_sticky, ch_lost_cnt);
        end
        set_per(0, 2);

        // random run against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                int c;
                c = $urandom_range(0, N - 1);
                per[c] = choices[$urandom_range(0, 7)];
                ph[c]  = 0;
            end
            for (int c = 0; c < N; c++) rsr[c] = ($urandom_range(0, 79) == 0);
            tick($urandom_range(0, 699) == 0, rsr, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
